adder8_arbiter: RTL and testbench

//   Shares one adder8 instance among NREQ requesters. Each requester issues an
//   8-bit add/subtract through a valid/ready handshake. A round-robin arbiter

---
 rtl/adder8_arbiter.sv | 141 ++++++++++++++
 tb/tb_adder8_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/adder8_arbiter.sv
// Round-robin front end that shares one 8-bit adder among NREQ requesters.
// Each accepted result goes into a single output register, tagged with the requester ID.

module adder8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] y,
  output logic       cout
);

  // 9-bit ripple sum; bit 8 is the carry out
  always_comb begin
    {cout, y} = {1'b0, a} + {1'b0, b} + {8'd0, cin};
  end

endmodule

module adder8_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*8-1:0] req_a,
  input  logic [NREQ*8-1:0] req_b,
  input  logic [NREQ-1:0]   req_sub,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [7:0]        rsp_y,
  output logic              rsp_carry
);

  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [7:0]      rsp_y_q, rsp_y_d;
  logic            rsp_carry_q, rsp_carry_d;

  logic [NREQ-1:0] grant_s;
  logic [IDW-1:0]  gnt_idx_s;
  logic            found_s;
  logic            can_load_s;
  logic            accept_s;
  logic [7:0]      op_a_s, op_b_s;
  logic            op_sub_s;
  logic [7:0]      sum_y_s;
  logic            sum_c_s;

  // Round-robin scan starting one past the last granted requester
  always_comb begin
    int idx;
    idx       = 0;
    grant_s   = '0;
    gnt_idx_s = '0;
    found_s   = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end else begin
        idx = idx;
      end
      if (!found_s && req_valid[idx]) begin
        grant_s[idx] = 1'b1;
        gnt_idx_s    = IDW'(idx);
        found_s      = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Operand mux; subtraction is a + ~b + 1 with the carry-in supplying the +1
  always_comb begin
    op_a_s   = req_a[8*int'(gnt_idx_s) +: 8];
    op_sub_s = req_sub[gnt_idx_s];
    op_b_s   = req_b[8*int'(gnt_idx_s) +: 8] ^ {8{op_sub_s}};
  end

  adder8 u_adder8 (
    .a    (op_a_s),
    .b    (op_b_s),
    .cin  (op_sub_s),
    .y    (sum_y_s),
    .cout (sum_c_s)
  );

  // Handshake: ready is held low while the block is in reset
  always_comb begin
    can_load_s = !rsp_valid_q || rsp_ready;
    accept_s   = found_s && can_load_s;
    req_ready  = grant_s & {NREQ{can_load_s && rst_n}};
  end

  // Next state of the output stage and the priority pointer
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_y_d     = rsp_y_q;
    rsp_carry_d = rsp_carry_q;
    if (accept_s) begin
      rr_ptr_d    = gnt_idx_s;
      rsp_valid_d = 1'b1;
      rsp_id_d    = gnt_idx_s;
      rsp_y_d     = sum_y_s;
      rsp_carry_d = sum_c_s;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end else begin
      rsp_valid_d = rsp_valid_q;
    end
  end

  // State registers; pointer resets to NREQ-1 so requester 0 wins first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= IDW'(NREQ - 1);
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_y_q     <= 8'd0;
      rsp_carry_q <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_y_q     <= rsp_y_d;
      rsp_carry_q <= rsp_carry_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_carry = rsp_carry_q;

endmodule

// File: tb/tb_adder8_arbiter.sv
// Directed bench for adder8_arbiter: arithmetic edges, round robin, backpressure
// and asynchronous reset, each result hand-computed.

module tb_adder8_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*8-1:0] req_a;
  logic [NREQ*8-1:0] req_b;
  logic [NREQ-1:0]   req_sub;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [7:0]        rsp_y;
  logic              rsp_carry;

  int n_checks = 0;
  int n_pass   = 0;

  adder8_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y),
    .rsp_carry (rsp_carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_op(input int idx, input logic [7:0] a, input logic [7:0] b, input logic sub);
    req_a[idx*8 +: 8] = a;
    req_b[idx*8 +: 8] = b;
    req_sub[idx]      = sub;
  endtask

  // One isolated request from requester idx, with the result checked after the edge
  task automatic do_op(input string tag, input int idx, input logic [7:0] a, input logic [7:0] b,
                       input logic sub, input logic [7:0] exp_y, input logic exp_c);
    logic [NREQ-1:0] onehot;
    onehot = '0;
    onehot[idx] = 1'b1;
    set_op(idx, a, b, sub);
    req_valid = onehot;
    #1;
    check({tag, "_ready"}, 32'(req_ready), 32'(onehot));
    @(posedge clk);
    #1;
    req_valid = '0;
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_id"}, 32'(rsp_id), 32'(idx));
    check({tag, "_y"}, 32'(rsp_y), 32'(exp_y));
    check({tag, "_carry"}, 32'(rsp_carry), 32'(exp_c));
  endtask

  initial begin
    logic [NREQ-1:0] exp_gnt;
    rst_n     = 1'b0;
    req_valid = {NREQ{1'b1}};
    req_a     = '0;
    req_b     = '0;
    req_sub   = '0;
    rsp_ready = 1'b1;

    // Reset state, with every request raised to show ready stays low
    @(posedge clk);
    #1;
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_id", 32'(rsp_id), 32'd0);
    check("rst_y", 32'(rsp_y), 32'd0);
    check("rst_carry", 32'(rsp_carry), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    req_valid = '0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single add, then a drain with nothing pending
    do_op("add5_5", 0, 8'd5, 8'd5, 1'b0, 8'd10, 1'b0);
    @(posedge clk);
    #1;
    check("drain_valid", 32'(rsp_valid), 32'd0);

    // Subtract and carry boundaries
    do_op("sub8_5", 1, 8'd8, 8'd5, 1'b1, 8'd3, 1'b1);
    do_op("sub5_8", 1, 8'd5, 8'd8, 1'b1, 8'hFD, 1'b0);
    do_op("sub80_1", 1, 8'h80, 8'd1, 1'b1, 8'h7F, 1'b1);
    do_op("add7f_1", 1, 8'h7F, 8'd1, 1'b0, 8'h80, 1'b0);
    do_op("sub0_0", 2, 8'd0, 8'd0, 1'b1, 8'd0, 1'b1);
    do_op("addff_1", 3, 8'hFF, 8'd1, 1'b0, 8'd0, 1'b1);

    // Round robin: last grant was 3, so order is 0,1,2,3,0
    for (int i = 0; i < NREQ; i++) set_op(i, 8'(10 * i), 8'd1, 1'b0);
    req_valid = {NREQ{1'b1}};
    for (int k = 0; k < 5; k++) begin
      exp_gnt = '0;
      exp_gnt[k % NREQ] = 1'b1;
      #1;
      check($sformatf("rr%0d_ready", k), 32'(req_ready), 32'(exp_gnt));
      @(posedge clk);
      #1;
      check($sformatf("rr%0d_valid", k), 32'(rsp_valid), 32'd1);
      check($sformatf("rr%0d_id", k), 32'(rsp_id), 32'(k % NREQ));
      check($sformatf("rr%0d_y", k), 32'(rsp_y), 32'(10 * (k % NREQ) + 1));
    end

    // Backpressure: stage holds id0/y=1 while req2 waits
    req_valid = 4'b0100;
    rsp_ready = 1'b0;
    #1;
    check("bp_ready0", 32'(req_ready), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp%0d_ready", c), 32'(req_ready), 32'd0);
      check($sformatf("bp%0d_valid", c), 32'(rsp_valid), 32'd1);
      check($sformatf("bp%0d_id", c), 32'(rsp_id), 32'd0);
      check($sformatf("bp%0d_y", c), 32'(rsp_y), 32'd1);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(req_ready), 32'b0100);
    @(posedge clk);
    #1;
    req_valid = '0;
    rsp_ready = 1'b0;
    check("bp_id", 32'(rsp_id), 32'd2);
    check("bp_y", 32'(rsp_y), 32'd21);
    check("bp_valid", 32'(rsp_valid), 32'd1);

    // Asynchronous reset mid-cycle while the stage is full
    #2;
    rst_n     = 1'b0;
    req_valid = {NREQ{1'b1}};
    #1;
    check("arst_valid", 32'(rsp_valid), 32'd0);
    check("arst_y", 32'(rsp_y), 32'd0);
    check("arst_ready", 32'(req_ready), 32'd0);
    #3;
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    set_op(0, 8'd0, 8'd1, 1'b0);
    #1;
    check("post_rst_ready", 32'(req_ready), 32'b0001);
    @(posedge clk);
    #1;
    check("post_rst_id", 32'(rsp_id), 32'd0);
    check("post_rst_y", 32'(rsp_y), 32'd1);
    req_valid = '0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
